// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the bank write port between write-back and the MDU, with an MDU pending scoreboard.
// Define ARB_STARVE_GUARD_EN to compile in the starvation counter and one-cycle STALL state.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              mdu_issue,
  input  logic [4:0]        mdu_issue_rd,
  input  logic [4:0]        ra,
  input  logic [4:0]        rb,
  output logic              hazard,
  output logic              stall,
  output logic              reg_write,
  output logic [4:0]        rw,
  output logic [DATA_W-1:0] busw
);
  logic              wb_grant, wr_en;
  logic [4:0]        wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       pending_q, pending_d;
  logic              reg_write_q;
  logic [4:0]        rw_q;
  logic [DATA_W-1:0] busw_q;
`ifdef ARB_STARVE_GUARD_EN
  typedef enum logic {NORMAL, STALL} state_e;
  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  always_comb begin
    wb_grant  = (state_q == NORMAL) & wb_valid;
    mdu_ready = (state_q == STALL) ? mdu_valid : mdu_valid & ~wb_valid;
    starve_d  = (mdu_valid & ~mdu_ready) ?
                ((starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1) : 4'd0;
    state_d   = (state_q == NORMAL && mdu_valid && !mdu_ready &&
                 starve_q == 4'(STARVE_LIMIT - 1)) ? STALL : NORMAL;
  end
  assign stall = (state_q == STALL);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  assign wb_grant  = wb_valid;
  assign mdu_ready = mdu_valid & ~wb_valid;
  assign stall     = 1'b0;
`endif
  // r0 requests are consumed but never strobed, so rw/busw keep their last value
  always_comb begin
    wr_rd     = wb_grant ? wb_rd : mdu_rd;
    wr_data   = wb_grant ? wb_data : mdu_data;
    wr_en     = (wb_grant | mdu_ready) & (|wr_rd);
    pending_d = ((pending_q & ~(mdu_ready ? 32'd1 << mdu_rd : 32'd0)) |
                 (mdu_issue ? 32'd1 << mdu_issue_rd : 32'd0)) & ~32'd1;
  end
  assign hazard = ((|ra) & pending_q[ra]) | ((|rb) & pending_q[rb]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      rw_q        <= 5'd0;
      busw_q      <= '0;
      pending_q   <= 32'd0;
    end else begin
      reg_write_q <= wr_en;
      pending_q   <= pending_d;
      if (wr_en) begin
        rw_q   <= wr_rd;
        busw_q <= wr_data;
      end
    end
  end
  assign reg_write = reg_write_q;
  assign rw        = rw_q;
  assign busw      = busw_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations for regfile_write_arbiter.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wb_valid = 1'b0, mdu_valid = 1'b0, mdu_issue = 1'b0;
  logic [4:0]  wb_rd = '0, mdu_rd = '0, mdu_issue_rd = '0, ra = '0, rb = '0;
  logic [31:0] wb_data = '0, mdu_data = '0;
  logic        mdu_ready, hazard, stall, reg_write;
  logic [4:0]  rw;
  logic [31:0] busw;
  int          n_checks = 0, n_fail = 0;
  regfile_write_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .ra(ra), .rb(rb), .hazard(hazard), .stall(stall),
    .reg_write(reg_write), .rw(rw), .busw(busw)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_busw", busw, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    #6 rst_n = 1'b1;
    tick();
    // single write-back
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    #1;
    check("wb_strobe", 32'(reg_write), 32'd1);
    check("wb_rw", 32'(rw), 32'd5);
    check("wb_busw", busw, 32'hDEADBEEF);
    tick();
    check("wb_one_cycle", 32'(reg_write), 32'd0);
    check("wb_hold_rw", 32'(rw), 32'd5);
    check("wb_hold_busw", busw, 32'hDEADBEEF);
    // contention: write-back first, MDU next
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    #1;
    check("cont_mdu_denied", 32'(mdu_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("cont_wb_strobe", 32'(reg_write), 32'd1);
    check("cont_wb_rw", 32'(rw), 32'd3);
    check("cont_wb_busw", busw, 32'h33);
    check("cont_mdu_ready", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    #1;
    check("cont_mdu_strobe", 32'(reg_write), 32'd1);
    check("cont_mdu_rw", 32'(rw), 32'd7);
    check("cont_mdu_busw", busw, 32'h77);
    tick();
    check("cont_idle", 32'(reg_write), 32'd0);
    // r0 write is swallowed
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    #1;
    check("r0_no_strobe", 32'(reg_write), 32'd0);
    check("r0_rw_hold", 32'(rw), 32'd7);
    check("r0_busw_hold", busw, 32'h77);
    tick();
    check("r0_no_strobe2", 32'(reg_write), 32'd0);
    // scoreboard
    mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
    tick();
    mdu_issue = 1'b0; ra = 5'd9;
    #1;
    check("sb_hazard_ra", 32'(hazard), 32'd1);
    ra = 5'd0; rb = 5'd9;
    #1;
    check("sb_hazard_rb", 32'(hazard), 32'd1);
    rb = 5'd8;
    #1;
    check("sb_no_hazard_r8", 32'(hazard), 32'd0);
    rb = 5'd9;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    #1;
    check("sb_mdu_ready", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    #1;
    check("sb_cleared", 32'(hazard), 32'd0);
    check("sb_write_rw", 32'(rw), 32'd9);
    mdu_issue = 1'b1;
    tick();
    mdu_valid = 1'b1;
    tick();
    mdu_issue = 1'b0; mdu_valid = 1'b0;
    #1;
    check("sb_set_wins", 32'(hazard), 32'd1);
    // starvation
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hAA;
    for (int k = 1; k <= 6; k++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      check($sformatf("starve_stall_c%0d", k), 32'(stall), 32'(k == 5));
      check($sformatf("starve_ready_c%0d", k), 32'(mdu_ready), 32'(k == 5));
      if (k == 6) check("starve_rw_c6", 32'(rw), 32'd10);
`else
      check($sformatf("nostarve_stall_c%0d", k), 32'(stall), 32'd0);
      check($sformatf("nostarve_ready_c%0d", k), 32'(mdu_ready), 32'd0);
      if (k == 6) check("nostarve_rw_c6", 32'(rw), 32'd4);
`endif
      if (k >= 2) check($sformatf("starve_strobe_c%0d", k), 32'(reg_write), 32'd1);
      tick();
    end
    mdu_valid = 1'b0;
    wb_rd = 5'd6; wb_data = 32'h66;
    tick();
    wb_valid = 1'b0; ra = 5'd9; rb = 5'd9;
    #1;
    check("pre_rst_strobe", 32'(reg_write), 32'd1);
    check("pre_rst_hazard", 32'(hazard), 32'd1);
    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_reg_write", 32'(reg_write), 32'd0);
    check("arst_rw", 32'(rw), 32'd0);
    check("arst_busw", busw, 32'd0);
    check("arst_hazard", 32'(hazard), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_strobe", 32'(reg_write), 32'd0);
    check("post_rst_hazard", 32'(hazard), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
